// File: rtl/glb_edge_start_pipe.sv
// -----------------------------------------------------------------------------
// glb_edge_start_pipe
//
// West-edge ingress of the global buffer tile chain. Processor requests are
// registered into the chain through a PIPE_DEPTH-stage pipe. In-flight
// processor reads are counted against a credit limit of MAX_OUTSTANDING.
// NUM_CFG config channels are forwarded east with a registered request path
// and a registered response path.
//
// Optional build macro:
//   GLB_EDGE_START_RD_TIMEOUT_EN
//     defined   : read timeout logic is built (age counter, timeout response,
//                 drop counter that swallows the late east response of each
//                 timed-out read).
//     undefined : reads wait indefinitely, proc_rd_err is tied low, and every
//                 valid east response retires one read while any are in flight.
//
// Ports:
//   clk                 clock
//   reset               asynchronous active-high reset
//   proc_req            {wr_en, rd_en, addr, strb, data} from the processor
//   proc_rd_ready       read credit available (in-flight reads < limit)
//   proc_rd_data        read response data
//   proc_rd_data_valid  read response strobe
//   proc_rd_err         response was produced by a timeout (data is 0)
//   est_proc_req        pipelined request toward the east tile
//   est_proc_rsp        {valid, data} read response from the east tile
//   cfg_req             per channel {wr_en, rd_en, addr, wr_data}
//   cfg_rsp             per channel {rd_data_valid, rd_data}, registered
//   est_cfg_req         cfg_req registered once, toward the east tile
//   est_cfg_rsp         per channel config responses from the east tile
// -----------------------------------------------------------------------------
module glb_edge_start_pipe #(
  parameter int DATA_W          = 64,
  parameter int ADDR_W          = 22,
  parameter int CFG_W           = 32,
  parameter int NUM_CFG         = 2,
  parameter int PIPE_DEPTH      = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RD_TIMEOUT      = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [2+ADDR_W+DATA_W/8+DATA_W-1:0] proc_req,
  output logic                                proc_rd_ready,
  output logic [DATA_W-1:0]                   proc_rd_data,
  output logic                                proc_rd_data_valid,
  output logic                                proc_rd_err,
  output logic [2+ADDR_W+DATA_W/8+DATA_W-1:0] est_proc_req,
  input  logic [DATA_W:0]                     est_proc_rsp,
  input  logic [NUM_CFG*(2+2*CFG_W)-1:0]      cfg_req,
  output logic [NUM_CFG*(1+CFG_W)-1:0]        cfg_rsp,
  output logic [NUM_CFG*(2+2*CFG_W)-1:0]      est_cfg_req,
  input  logic [NUM_CFG*(1+CFG_W)-1:0]        est_cfg_rsp
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int REQ_W     = 2 + ADDR_W + STRB_W + DATA_W;
  localparam int WR_BIT    = REQ_W - 1;
  localparam int RD_BIT    = REQ_W - 2;
  localparam int CFG_REQ_W = 2 + 2 * CFG_W;
  localparam int CFG_RSP_W = 1 + CFG_W;
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  // ---------------------------------------------------------------------------
  // Read acceptance and request pipe
  // ---------------------------------------------------------------------------
  logic             rd_accept;
  logic [REQ_W-1:0] req_in;

  logic [OUT_W-1:0] out_q;
  logic             have_out;

  assign proc_rd_ready = (out_q < OUT_MAX);
  assign have_out      = (out_q != '0);

  // A read only enters the chain when it is a pure read and a credit is
  // free; a write always wins over a simultaneous read.
  assign rd_accept = proc_req[RD_BIT] & ~proc_req[WR_BIT] & proc_rd_ready;

  always_comb begin
    req_in         = proc_req;
    req_in[RD_BIT] = rd_accept;
  end

  logic [PIPE_DEPTH-1:0][REQ_W-1:0] pipe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= req_in;
      for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign est_proc_req = pipe_q[PIPE_DEPTH-1];

  // ---------------------------------------------------------------------------
  // Read response tracking
  // ---------------------------------------------------------------------------
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_take;
  logic              retire;

  assign rsp_valid = est_proc_rsp[DATA_W];
  assign rsp_data  = est_proc_rsp[DATA_W-1:0];

`ifdef GLB_EDGE_START_RD_TIMEOUT_EN
  localparam int               AGE_W    = $clog2(RD_TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(RD_TIMEOUT - 1);
  localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);

  logic [AGE_W-1:0] age_q;
  logic [OUT_W-1:0] drop_q;
  logic [OUT_W-1:0] drop_next;
  logic             rsp_discard;
  logic             timeout_fire;

  // Responses are in order, so while timed-out reads still owe a response
  // from the east, the next responses to arrive belong to them and are
  // swallowed rather than credited to the oldest live read.
  assign rsp_discard  = rsp_valid & (drop_q != '0);
  assign rsp_take     = rsp_valid & (drop_q == '0) & have_out;
  // A real response at the terminal age wins over the timeout.
  assign timeout_fire = have_out & (age_q == AGE_LAST) & ~rsp_take;
  assign retire       = rsp_take | timeout_fire;

  // Age of the oldest in-flight read; restarts on every retire so the next
  // read gets a full timeout window measured from that point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_q <= '0;
    end else if (retire || !have_out) begin
      age_q <= '0;
    end else begin
      age_q <= age_q + AGE_ONE;
    end
  end

  // Discard and timeout can coincide; the discard is applied first so the
  // saturation check sees the post-discard value.
  always_comb begin
    drop_next = drop_q;
    if (rsp_discard) begin
      drop_next = drop_q - OUT_ONE;
    end
    if (timeout_fire && (drop_next != OUT_MAX)) begin
      drop_next = drop_next + OUT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proc_rd_err <= 1'b0;
    end else begin
      proc_rd_err <= timeout_fire;
    end
  end
`else
  assign rsp_take    = rsp_valid & have_out;
  assign retire      = rsp_take;
  assign proc_rd_err = 1'b0;
`endif

  // Accept and retire in the same cycle cancel out. Retire only happens with
  // reads in flight and accept only with a free credit, so the count never
  // wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      case ({rd_accept, retire})
        2'b10:   out_q <= out_q + OUT_ONE;
        2'b01:   out_q <= out_q - OUT_ONE;
        default: out_q <= out_q;
      endcase
    end
  end

  // Data is forced to 0 on a timeout response and whenever no response is
  // being presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proc_rd_data_valid <= 1'b0;
      proc_rd_data       <= '0;
    end else begin
      proc_rd_data_valid <= retire;
      proc_rd_data       <= rsp_take ? rsp_data : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Config channels: one register each way, channels kept independent
  // ---------------------------------------------------------------------------
  for (genvar ch = 0; ch < NUM_CFG; ch++) begin : g_cfg
    logic [CFG_REQ_W-1:0] req_q;
    logic [CFG_RSP_W-1:0] rsp_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        req_q <= '0;
        rsp_q <= '0;
      end else begin
        req_q <= cfg_req[ch*CFG_REQ_W +: CFG_REQ_W];
        rsp_q <= est_cfg_rsp[ch*CFG_RSP_W +: CFG_RSP_W];
      end
    end

    assign est_cfg_req[ch*CFG_REQ_W +: CFG_REQ_W] = req_q;
    assign cfg_rsp[ch*CFG_RSP_W +: CFG_RSP_W]     = rsp_q;
  end

endmodule

// File: tb/tb_glb_edge_start_pipe.sv
// -----------------------------------------------------------------------------
// tb_glb_edge_start_pipe
//
// Self-checking bench for glb_edge_start_pipe with PIPE_DEPTH=2,
// MAX_OUTSTANDING=4, RD_TIMEOUT=64, NUM_CFG=2. A cycle table covers the
// request pipe, credit limit, in-order responses, write-plus-read and a
// spurious response; hand sequences cover timeout (or indefinite wait when
// GLB_EDGE_START_RD_TIMEOUT_EN is undefined), config forwarding and reset
// in the middle of traffic.
// -----------------------------------------------------------------------------
module tb_glb_edge_start_pipe;

  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 22;
  localparam int CFG_W      = 32;
  localparam int NUM_CFG    = 2;
  localparam int PIPE_DEPTH = 2;
  localparam int MAX_OUT    = 4;
  localparam int RD_TIMEOUT = 64;

  localparam int REQ_W  = 2 + ADDR_W + DATA_W / 8 + DATA_W;
  localparam int CREQ_W = 2 + 2 * CFG_W;
  localparam int CRSP_W = 1 + CFG_W;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [REQ_W-1:0]            proc_req;
  logic                        proc_rd_ready;
  logic [DATA_W-1:0]           proc_rd_data;
  logic                        proc_rd_data_valid;
  logic                        proc_rd_err;
  logic [REQ_W-1:0]            est_proc_req;
  logic [DATA_W:0]             est_proc_rsp;
  logic [NUM_CFG*CREQ_W-1:0]   cfg_req;
  logic [NUM_CFG*CRSP_W-1:0]   cfg_rsp;
  logic [NUM_CFG*CREQ_W-1:0]   est_cfg_req;
  logic [NUM_CFG*CRSP_W-1:0]   est_cfg_rsp;

  glb_edge_start_pipe #(
    .DATA_W          (DATA_W),
    .ADDR_W          (ADDR_W),
    .CFG_W           (CFG_W),
    .NUM_CFG         (NUM_CFG),
    .PIPE_DEPTH      (PIPE_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT),
    .RD_TIMEOUT      (RD_TIMEOUT)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .proc_req           (proc_req),
    .proc_rd_ready      (proc_rd_ready),
    .proc_rd_data       (proc_rd_data),
    .proc_rd_data_valid (proc_rd_data_valid),
    .proc_rd_err        (proc_rd_err),
    .est_proc_req       (est_proc_req),
    .est_proc_rsp       (est_proc_rsp),
    .cfg_req            (cfg_req),
    .cfg_rsp            (cfg_rsp),
    .est_cfg_req        (est_cfg_req),
    .est_cfg_rsp        (est_cfg_rsp)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input logic wr, input logic rd,
                                              input logic [ADDR_W-1:0] addr,
                                              input logic [7:0] strb,
                                              input logic [DATA_W-1:0] data);
    return {wr, rd, addr, strb, data};
  endfunction

  function automatic logic [CREQ_W-1:0] mk_cfg(input logic wr, input logic rd,
                                               input logic [CFG_W-1:0] addr,
                                               input logic [CFG_W-1:0] data);
    return {wr, rd, addr, data};
  endfunction

  function automatic logic [REQ_W-1:0] rd_req(input logic [ADDR_W-1:0] addr);
    return mk_req(1'b0, 1'b1, addr, 8'h00, 64'h0);
  endfunction

  // Inputs are changed and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " est_proc_req"}, 136'(est_proc_req), 136'(0));
    chk({tag, " rd_ready"},     136'(proc_rd_ready), 136'(1));
    chk({tag, " rd_valid"},     136'(proc_rd_data_valid), 136'(0));
    chk({tag, " rd_data"},      136'(proc_rd_data), 136'(0));
    chk({tag, " rd_err"},       136'(proc_rd_err), 136'(0));
    chk({tag, " est_cfg_req"},  136'(est_cfg_req), 136'(0));
    chk({tag, " cfg_rsp"},      136'(cfg_rsp), 136'(0));
  endtask

  typedef struct {
    logic [REQ_W-1:0]  req;
    logic              rsp_v;
    logic [DATA_W-1:0] rsp_d;
    logic [REQ_W-1:0]  exp_est;
    logic              exp_rdy;
    logic              exp_vld;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  function automatic vec_t mk_vec(input logic [REQ_W-1:0] req, input logic rsp_v,
                                  input logic [DATA_W-1:0] rsp_d,
                                  input logic [REQ_W-1:0] exp_est, input logic exp_rdy,
                                  input logic exp_vld, input logic [DATA_W-1:0] exp_data);
    vec_t v;
    v.req      = req;
    v.rsp_v    = rsp_v;
    v.rsp_d    = rsp_d;
    v.exp_est  = exp_est;
    v.exp_rdy  = exp_rdy;
    v.exp_vld  = exp_vld;
    v.exp_data = exp_data;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t             tbl [16];
    logic [REQ_W-1:0] wr0;
    logic [REQ_W-1:0] wrd;
    logic [NUM_CFG*CREQ_W-1:0] cfg_exp;

    wr0 = mk_req(1'b1, 1'b0, 22'h100, 8'hFF, 64'hDEADBEEF00000001);
    wrd = mk_req(1'b1, 1'b1, 22'h3FFFFF, 8'h0F, 64'h0123456789ABCDEF);

    // Row k: outputs expected during cycle k, then the inputs driven in cycle k.
    tbl[0]  = mk_vec(wr0,        0, 64'h0,  '0,         1, 0, 64'h0);
    tbl[1]  = mk_vec('0,         0, 64'h0,  '0,         1, 0, 64'h0);
    tbl[2]  = mk_vec(rd_req(1),  0, 64'h0,  wr0,        1, 0, 64'h0);
    tbl[3]  = mk_vec(rd_req(2),  0, 64'h0,  '0,         1, 0, 64'h0);
    tbl[4]  = mk_vec(rd_req(3),  0, 64'h0,  rd_req(1),  1, 0, 64'h0);
    tbl[5]  = mk_vec(rd_req(4),  0, 64'h0,  rd_req(2),  1, 0, 64'h0);
    tbl[6]  = mk_vec(rd_req(5),  0, 64'h0,  rd_req(3),  0, 0, 64'h0);
    tbl[7]  = mk_vec('0,         1, 64'hAB, rd_req(4),  0, 0, 64'h0);
    tbl[8]  = mk_vec('0,         1, 64'h11, mk_req(0, 0, 22'h5, 8'h0, 64'h0), 1, 1, 64'hAB);
    tbl[9]  = mk_vec('0,         1, 64'h22, '0,         1, 1, 64'h11);
    tbl[10] = mk_vec('0,         1, 64'h33, '0,         1, 1, 64'h22);
    tbl[11] = mk_vec(wrd,        0, 64'h0,  '0,         1, 1, 64'h33);
    tbl[12] = mk_vec('0,         0, 64'h0,  '0,         1, 0, 64'h0);
    tbl[13] = mk_vec('0,         1, 64'h99, mk_req(1, 0, 22'h3FFFFF, 8'h0F, 64'h0123456789ABCDEF), 1, 0, 64'h0);
    tbl[14] = mk_vec('0,         0, 64'h0,  '0,         1, 0, 64'h0);
    tbl[15] = mk_vec('0,         0, 64'h0,  '0,         1, 0, 64'h0);

    reset        = 1'b1;
    proc_req     = '0;
    est_proc_rsp = '0;
    cfg_req      = '0;
    est_cfg_rsp  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    reset = 1'b0;
    step();
    chk_all_zero("after_reset");

    // ---------------- table: pipe, credits, in-order responses -------------
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("row%0d est_proc_req", i), 136'(est_proc_req), 136'(tbl[i].exp_est));
      chk($sformatf("row%0d rd_ready", i), 136'(proc_rd_ready), 136'(tbl[i].exp_rdy));
      chk($sformatf("row%0d rd_valid", i), 136'(proc_rd_data_valid), 136'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) begin
        chk($sformatf("row%0d rd_data", i), 136'(proc_rd_data), 136'(tbl[i].exp_data));
        chk($sformatf("row%0d rd_err", i), 136'(proc_rd_err), 136'(0));
      end
      proc_req     = tbl[i].req;
      est_proc_rsp = {tbl[i].rsp_v, tbl[i].rsp_d};
      step();
    end
    proc_req     = '0;
    est_proc_rsp = '0;

`ifdef GLB_EDGE_START_RD_TIMEOUT_EN
    // ---------------- timeout of a silent read ----------------------------
    proc_req = rd_req(22'h7);
    step();
    proc_req = '0;
    for (int j = 1; j <= RD_TIMEOUT; j++) begin
      chk($sformatf("to_wait c%0d rd_valid", j), 136'(proc_rd_data_valid), 136'(0));
      step();
    end
    chk("timeout rd_valid", 136'(proc_rd_data_valid), 136'(1));
    chk("timeout rd_err",   136'(proc_rd_err), 136'(1));
    chk("timeout rd_data",  136'(proc_rd_data), 136'(0));
    chk("timeout rd_ready", 136'(proc_rd_ready), 136'(1));
    repeat (15) step();
    est_proc_rsp = {1'b1, 64'h55};
    step();
    est_proc_rsp = '0;
    chk("late_rsp dropped c81", 136'(proc_rd_data_valid), 136'(0));
    step();
    chk("late_rsp dropped c82", 136'(proc_rd_data_valid), 136'(0));
    proc_req = rd_req(22'h8);
    step();
    proc_req = '0;
    step();
    est_proc_rsp = {1'b1, 64'h66};
    step();
    est_proc_rsp = '0;
    chk("post_drop rd_valid", 136'(proc_rd_data_valid), 136'(1));
    chk("post_drop rd_data",  136'(proc_rd_data), 136'(64'h66));
    chk("post_drop rd_err",   136'(proc_rd_err), 136'(0));
    step();

    // ---------------- response at the terminal-age edge wins ---------------
    proc_req = rd_req(22'h9);
    step();
    proc_req = '0;
    repeat (RD_TIMEOUT - 1) step();
    chk("edge_rsp pre rd_valid", 136'(proc_rd_data_valid), 136'(0));
    est_proc_rsp = {1'b1, 64'h77};
    step();
    est_proc_rsp = '0;
    chk("edge_rsp rd_valid", 136'(proc_rd_data_valid), 136'(1));
    chk("edge_rsp rd_data",  136'(proc_rd_data), 136'(64'h77));
    chk("edge_rsp rd_err",   136'(proc_rd_err), 136'(0));
    step();
    chk("edge_rsp no_extra", 136'(proc_rd_data_valid), 136'(0));
    proc_req = rd_req(22'hA);
    step();
    proc_req = '0;
    step();
    est_proc_rsp = {1'b1, 64'h88};
    step();
    est_proc_rsp = '0;
    chk("edge_rsp next rd_valid", 136'(proc_rd_data_valid), 136'(1));
    chk("edge_rsp next rd_data",  136'(proc_rd_data), 136'(64'h88));
    step();
`else
    // ---------------- reads wait indefinitely -----------------------------
    proc_req = rd_req(22'h7);
    step();
    proc_req = '0;
    for (int j = 1; j <= 100; j++) begin
      chk($sformatf("no_to c%0d rd_valid", j), 136'(proc_rd_data_valid), 136'(0));
      step();
    end
    chk("no_to rd_ready", 136'(proc_rd_ready), 136'(1));
    est_proc_rsp = {1'b1, 64'h55};
    step();
    est_proc_rsp = '0;
    chk("slow_rsp rd_valid", 136'(proc_rd_data_valid), 136'(1));
    chk("slow_rsp rd_data",  136'(proc_rd_data), 136'(64'h55));
    chk("slow_rsp rd_err",   136'(proc_rd_err), 136'(0));
    step();
    est_proc_rsp = {1'b1, 64'h66};
    step();
    est_proc_rsp = '0;
    chk("spurious rd_valid", 136'(proc_rd_data_valid), 136'(0));
    step();
`endif

    // ---------------- config channels ---------------------------------------
    cfg_exp = {mk_cfg(1'b0, 1'b1, 32'h20, 32'h0), mk_cfg(1'b1, 1'b0, 32'h10, 32'h5)};
    cfg_req = cfg_exp;
    step();
    chk("cfg c1 est_cfg_req", 136'(est_cfg_req), 136'(cfg_exp));
    chk("cfg c1 cfg_rsp",     136'(cfg_rsp), 136'(0));
    cfg_exp = {mk_cfg(1'b0, 1'b0, 32'h0, 32'h0), mk_cfg(1'b1, 1'b1, 32'hABC, 32'hF00D)};
    cfg_req = cfg_exp;
    step();
    chk("cfg c2 wr_rd est_cfg_req", 136'(est_cfg_req), 136'(cfg_exp));
    cfg_req = '0;
    step();
    chk("cfg c3 est_cfg_req", 136'(est_cfg_req), 136'(0));
    chk("cfg c3 cfg_rsp",     136'(cfg_rsp), 136'(0));
    est_cfg_rsp = {1'b1, 32'h77, 1'b0, 32'h0};
    step();
    est_cfg_rsp = '0;
    chk("cfg c4 cfg_rsp", 136'(cfg_rsp), 136'({1'b1, 32'h77, 1'b0, 32'h0}));
    step();
    chk("cfg c5 cfg_rsp", 136'(cfg_rsp), 136'(0));

    // ---------------- reset with reads in flight ----------------------------
    proc_req = rd_req(22'h31);
    step();
    proc_req = rd_req(22'h32);
    step();
    proc_req    = rd_req(22'h33);
    cfg_req     = {mk_cfg(1'b1, 1'b0, 32'h1, 32'h2), mk_cfg(1'b0, 1'b1, 32'h3, 32'h0)};
    est_cfg_rsp = {1'b1, 32'h5, 1'b1, 32'h6};
    step();
    chk("pre_reset est_proc_req", 136'(est_proc_req), 136'(rd_req(22'h32)));
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1;
    chk("reset_edge est_proc_req", 136'(est_proc_req), 136'(0));
    chk("reset_edge est_cfg_req",  136'(est_cfg_req), 136'(0));
    chk("reset_edge cfg_rsp",      136'(cfg_rsp), 136'(0));
    chk("reset_edge rd_ready",     136'(proc_rd_ready), 136'(1));
    proc_req    = '0;
    cfg_req     = '0;
    est_cfg_rsp = '0;
    #2;
    reset = 1'b0;
    step();
    est_proc_rsp = {1'b1, 64'h44};
    step();
    est_proc_rsp = '0;
    chk("post_reset rsp ignored", 136'(proc_rd_data_valid), 136'(0));
    step();
    chk("post_reset rsp ignored2", 136'(proc_rd_data_valid), 136'(0));
    for (int k = 0; k < MAX_OUT; k++) begin
      proc_req = rd_req(22'(k + 1));
      step();
      chk($sformatf("post_reset credit %0d", k + 1), 136'(proc_rd_ready),
          136'((k < MAX_OUT - 1) ? 1 : 0));
    end
    proc_req = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
